// File: rtl/ibex_alu_pext_shift_seq.sv
// ibex_alu_pext_shift_seq
//   Multi-cycle packed-SIMD shift / saturate unit for the EX stage. It accepts
//   one op through a valid/ready handshake and processes one lane per cycle:
//   one lane for 32-bit, two for 16-bit and four for 8-bit. It presents the
//   packed result through a second valid/ready handshake and keeps the sticky
//   vxsat saturation flag for the CSR file.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i / ready_o    op request / unit idle and able to accept
//   operand_a_i          packed source lanes
//   shamt_i              shift amount (two's complement field for KSLRA)
//   shift_op_i           00 SLL, 01 SRL, 10 SRA, 11 KSLRA
//   width32_i, width8_i  lane width select (32 wins over 8, neither = 16)
//   signed_ops_i         signed saturation bounds
//   rounding_i           round right shifts
//   saturate_i           saturate left shifts
//   kill_i               abort the in-flight op
//   valid_o / ready_i    result available / consumer accepts it
//   result_o, ov_o       packed result, some lane saturated in this op
//   vxsat_clr_i          CSR write clearing vxsat
//   vxsat_o              sticky saturation flag
module ibex_alu_pext_shift_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] operand_a_i,
  input  logic [5:0]  shamt_i,
  input  logic [1:0]  shift_op_i,
  input  logic        width32_i,
  input  logic        width8_i,
  input  logic        signed_ops_i,
  input  logic        rounding_i,
  input  logic        saturate_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        ov_o,
  input  logic        vxsat_clr_i,
  output logic        vxsat_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;

  logic [31:0] op_a;
  logic [5:0]  shamt;
  logic [1:0]  op;
  logic        w32, w8, sgn, rnd, sat;
  logic [1:0]  lane;
  logic [31:0] result;
  logic        ov, vxsat;

  logic        accept, handshake, last_lane;

  // Per-lane datapath signals; all lane math is done at 64 bits so that
  // shifted-out bits and the rounding carry are never lost.
  logic [5:0]  w;
  logic [2:0]  lw;
  logic [1:0]  last_idx;
  logic [4:0]  base;
  logic [63:0] lane_mask, raw, x_s, src, sum, full, res, res_sext, clamp;
  logic signed [63:0] sra_v;
  logic [6:0]  fld;
  logic [5:0]  mag, amt_neg, amt;
  logic        neg, left, arith, do_sat, do_round, over, lane_ov;

  assign accept    = (state == IDLE) && valid_i;
  assign handshake = (state == DONE) && ready_i && !kill_i;
  assign last_lane = (lane == last_idx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_o    = (state == IDLE);
    valid_o    = (state == DONE);
    unique case (state)
      IDLE:    if (valid_i) state_next = BUSY;
      BUSY: begin
        if (kill_i)         state_next = IDLE;
        else if (last_lane) state_next = DONE;
      end
      DONE:    if (kill_i || ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane geometry and the per-lane shift/round/saturate computation.
  always_comb begin
    w        = 6'd16;
    lw       = 3'd4;
    last_idx = 2'd1;
    base     = {lane[0], 4'b0000};
    if (w32) begin
      w        = 6'd32;
      lw       = 3'd5;
      last_idx = 2'd0;
      base     = 5'd0;
    end else if (w8) begin
      w        = 6'd8;
      lw       = 3'd3;
      last_idx = 2'd3;
      base     = {lane, 3'b000};
    end

    lane_mask = (64'd1 << w) - 64'd1;
    raw       = {32'b0, op_a >> base} & lane_mask;
    x_s       = raw[w - 6'd1] ? (raw | ~lane_mask) : raw;

    // KSLRA uses a log2(W)+1 bit signed field; a negative value means an
    // arithmetic right shift, capped at W-1 so the sign is always kept.
    fld     = {1'b0, shamt} & ((7'd2 << lw) - 7'd1);
    neg     = shamt[lw];
    mag     = 6'((7'd2 << lw) - fld);
    amt_neg = (mag > (w - 6'd1)) ? (w - 6'd1) : mag;

    left     = 1'b0;
    arith    = 1'b0;
    do_sat   = 1'b0;
    do_round = rnd;
    amt      = shamt & (w - 6'd1);
    if (op == 2'b11) begin
      if (neg) begin
        arith = 1'b1;
        amt   = amt_neg;
      end else begin
        left   = 1'b1;
        do_sat = 1'b1;
        amt    = fld[5:0];
      end
    end else begin
      left   = (op == 2'b00);
      arith  = (op == 2'b10);
      do_sat = sat;
    end

    // Right shifts: the rounding increment is added before shifting.
    src   = arith ? x_s : raw;
    sum   = src;
    if (!left && do_round && (amt != 6'd0)) sum = src + (64'd1 << (amt - 6'd1));
    sra_v = $signed(sum) >>> amt;

    full     = (sgn ? x_s : raw) << amt;
    res      = left ? (full & lane_mask)
                    : ((arith ? $unsigned(sra_v) : (sum >> amt)) & lane_mask);
    res_sext = res[w - 6'd1] ? (res | ~lane_mask) : res;

    // A left shift overflows when anything above the lane disagrees with
    // the sign-extended (signed) or zero-extended (unsigned) result.
    if (sgn) begin
      over  = (full != res_sext);
      clamp = x_s[63] ? (64'd1 << (w - 6'd1)) : (lane_mask >> 1);
    end else begin
      over  = ((full & ~lane_mask) != 64'd0);
      clamp = lane_mask;
    end
    lane_ov = left && do_sat && over;
    if (lane_ov) res = clamp;
  end

  // Operand latch, lane sequencing and result assembly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a   <= 32'd0;
      shamt  <= 6'd0;
      op     <= 2'd0;
      w32    <= 1'b0;
      w8     <= 1'b0;
      sgn    <= 1'b0;
      rnd    <= 1'b0;
      sat    <= 1'b0;
      lane   <= 2'd0;
      result <= 32'd0;
      ov     <= 1'b0;
    end else if (accept) begin
      op_a   <= operand_a_i;
      shamt  <= shamt_i;
      op     <= shift_op_i;
      w32    <= width32_i;
      w8     <= width8_i;
      sgn    <= signed_ops_i;
      rnd    <= rounding_i;
      sat    <= saturate_i;
      lane   <= 2'd0;
      result <= 32'd0;
      ov     <= 1'b0;
    end else if ((state == BUSY) && !kill_i) begin
      result <= (result & ~(lane_mask[31:0] << base)) | (res[31:0] << base);
      ov     <= ov | lane_ov;
      lane   <= lane + 2'd1;
    end else if ((state != IDLE) && kill_i) begin
      ov <= 1'b0;
    end
  end

  // Sticky saturation flag; a completing saturated op beats a CSR clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                vxsat <= 1'b0;
    else if (handshake && ov)   vxsat <= 1'b1;
    else if (vxsat_clr_i)       vxsat <= 1'b0;
  end

  assign result_o = result;
  assign ov_o     = ov;
  assign vxsat_o  = vxsat;

endmodule

// File: tb/tb_ibex_alu_pext_shift_seq.sv
// tb_ibex_alu_pext_shift_seq
//   Table of {operands, controls, expected result, expected ov} vectors,
//   pushed to a scoreboard queue on acceptance and popped when valid_o is
//   seen, plus hand-written sequences for backpressure, kill, vxsat and
//   asynchronous reset.
module tb_ibex_alu_pext_shift_seq;

  logic        clk, rst_n;
  logic        valid_i, ready_o, kill_i, valid_o, ready_i;
  logic [31:0] operand_a, result_o;
  logic [5:0]  shamt;
  logic [1:0]  shift_op;
  logic        width32, width8, signed_ops, rounding, saturate;
  logic        ov_o, vxsat_clr, vxsat_o;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  shamt;
    logic [1:0]  op;
    logic        w32;
    logic        w8;
    logic        sgn;
    logic        rnd;
    logic        sat;
    logic [31:0] res;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[14];
  int   checks = 0;
  int   fails  = 0;
  logic vx_model = 1'b0;

  ibex_alu_pext_shift_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operand_a_i  (operand_a),
    .shamt_i      (shamt),
    .shift_op_i   (shift_op),
    .width32_i    (width32),
    .width8_i     (width8),
    .signed_ops_i (signed_ops),
    .rounding_i   (rounding),
    .saturate_i   (saturate),
    .kill_i       (kill_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .ov_o         (ov_o),
    .vxsat_clr_i  (vxsat_clr),
    .vxsat_o      (vxsat_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [5:0] sh,
                              input logic [1:0] op, input logic w32, input logic w8,
                              input logic sgn, input logic rnd, input logic sat,
                              input logic [31:0] res, input logic ov);
    vec_t v;
    v.a = a; v.shamt = sh; v.op = op; v.w32 = w32; v.w8 = w8;
    v.sgn = sgn; v.rnd = rnd; v.sat = sat; v.res = res; v.ov = ov;
    v.lat = w32 ? 2 : (w8 ? 5 : 3);
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the accepting edge.
  task automatic apply_stimulus(input vec_t v, input bit push);
    int n;
    operand_a = v.a; shamt = v.shamt; shift_op = v.op;
    width32 = v.w32; width8 = v.w8; signed_ops = v.sgn;
    rounding = v.rnd; saturate = v.sat; valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++; fails++;
      $display("[TB] FAIL accept_timeout: ready_o got 0 expected 1");
    end
    @(posedge clk);
    if (push) sb_q.push_back(v);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      valid_i = 1'b0;
      cyc++;
    end while (!valid_o && cyc < 40);
    if (!valid_o) begin
      checks++; fails++;
      $display("[TB] FAIL valid_timeout: valid_o got 0 expected 1");
    end
  endtask

  task automatic finish_op(input logic clr, input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++; fails++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check_output({tag, "_result"}, result_o, e.res);
    check_output({tag, "_ov"}, {31'b0, ov_o}, {31'b0, e.ov});
    ready_i = 1'b1;
    vxsat_clr = clr;
    @(posedge clk);
    vx_model = e.ov | (vx_model & ~clr);
    @(negedge clk);
    ready_i = 1'b0;
    vxsat_clr = 1'b0;
    check_output({tag, "_vxsat"}, {31'b0, vxsat_o}, {31'b0, vx_model});
  endtask

  task automatic do_op(input vec_t v, input logic clr, input string tag);
    int cyc;
    apply_stimulus(v, 1'b1);
    wait_valid(cyc);
    check_output({tag, "_latency"}, cyc, v.lat);
    finish_op(clr, tag);
  endtask

  initial begin
    int   cyc;
    bit   seen;
    vec_t v1, v2;

    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0; vxsat_clr = 1'b0;
    operand_a = '0; shamt = '0; shift_op = '0; width32 = 1'b0; width8 = 1'b0;
    signed_ops = 1'b0; rounding = 1'b0; saturate = 1'b0;

    //                a             shamt      op     w32   w8    sgn   rnd   sat   result        ov
    vecs[0]  = mk(32'h807F03FD, 6'd1,      2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC04002FF, 1'b0);
    vecs[1]  = mk(32'h4000FFFF, 6'd2,      2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7FFFFFFC, 1'b1);
    vecs[2]  = mk(32'h80000000, 6'b100000, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);
    vecs[3]  = mk(32'h12345678, 6'd36,     2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h23456780, 1'b0);
    vecs[4]  = mk(32'hF0F08001, 6'd4,      2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0F0F0800, 1'b0);
    vecs[5]  = mk(32'hFF0F8003, 6'd1,      2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80084002, 1'b0);
    vecs[6]  = mk(32'h40FF0180, 6'd1,      2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80FF02FF, 1'b1);
    vecs[7]  = mk(32'h40C0BF01, 6'd1,      2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7F808002, 1'b1);
    vecs[8]  = mk(32'h00017FFF, 6'b000011, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00087FFF, 1'b1);
    vecs[9]  = mk(32'h80F07F10, 6'b111110, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hE0FC1F04, 1'b0);
    vecs[10] = mk(32'h80017F00, 6'b001000, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b0);
    vecs[11] = mk(32'h80000010, 6'b010011, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hF0000002, 1'b0);
    vecs[12] = mk(32'hABCD1234, 6'd8,      2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCD003400, 1'b0);
    vecs[13] = mk(32'h80000000, 6'd31,     2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_ready", {31'b0, ready_o}, 32'd1);
    check_output("rst_valid", {31'b0, valid_o}, 32'd0);
    check_output("rst_result", result_o, 32'd0);
    check_output("rst_ov", {31'b0, ov_o}, 32'd0);
    check_output("rst_vxsat", {31'b0, vxsat_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Backpressure with a second request waiting for IDLE.
    v1 = mk(32'h12345678, 6'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0);
    v2 = mk(32'h0000FF00, 6'd8, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000000FF, 1'b0);
    apply_stimulus(v1, 1'b1);
    wait_valid(cyc);
    check_output("bp_latency", cyc, 2);
    operand_a = v2.a; shamt = v2.shamt; shift_op = v2.op; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("bp_valid%0d", i), {31'b0, valid_o}, 32'd1);
      check_output($sformatf("bp_result%0d", i), result_o, 32'h12345678);
      check_output($sformatf("bp_ready%0d", i), {31'b0, ready_o}, 32'd0);
      @(negedge clk);
    end
    finish_op(1'b0, "bp_first");
    check_output("bp_idle_ready", {31'b0, ready_o}, 32'd1);
    apply_stimulus(v2, 1'b1);
    wait_valid(cyc);
    check_output("bp_second_latency", cyc, 2);
    finish_op(1'b0, "bp_second");

    // Kill during an 8-bit saturating SLL.
    vxsat_clr = 1'b1;
    @(negedge clk);
    vxsat_clr = 1'b0;
    vx_model = 1'b0;
    check_output("clr_vxsat", {31'b0, vxsat_o}, 32'd0);
    apply_stimulus(mk(32'hFFFFFFFF, 6'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1), 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check_output("kill_ready", {31'b0, ready_o}, 32'd1);
    seen = valid_o;
    repeat (6) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    check_output("kill_no_valid", {31'b0, seen}, 32'd0);
    check_output("kill_vxsat", {31'b0, vxsat_o}, 32'd0);

    // Clear coincident with a saturating handshake, then a lone clear.
    do_op(vecs[6], 1'b1, "clr_coincident");
    vxsat_clr = 1'b1;
    @(negedge clk);
    vxsat_clr = 1'b0;
    vx_model = 1'b0;
    check_output("clr_alone_vxsat", {31'b0, vxsat_o}, 32'd0);

    // Asynchronous reset in the middle of BUSY.
    do_op(vecs[1], 1'b0, "pre_reset");
    apply_stimulus(mk(32'hFFFFFFFF, 6'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_valid", {31'b0, valid_o}, 32'd0);
    check_output("arst_result", result_o, 32'd0);
    check_output("arst_ov", {31'b0, ov_o}, 32'd0);
    check_output("arst_vxsat", {31'b0, vxsat_o}, 32'd0);
    check_output("arst_ready", {31'b0, ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vx_model = 1'b0;
    @(negedge clk);
    do_op(vecs[0], 1'b0, "post_reset");

    check_output("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
